// File: rtl/uart_pkg.sv
// uart_pkg
//   Shared types and register layout for the UART receive path.
//   rx_state_t   : receiver FSM states
//   RX_VALID_BIT : position of the "byte valid" flag in the data register
//   ST_*         : bit positions inside the status register
//   data_word()  : packs the data register image
//   stat_word()  : packs the status register image
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    STOP,
    BREAK
  } rx_state_t;

  localparam int RX_VALID_BIT = 9;
  localparam int ST_NEMPTY    = 0;
  localparam int ST_FULL      = 1;
  localparam int ST_OVR       = 2;
  localparam int ST_FERR      = 3;

  // {22'b0, valid, 1'b0, byte[7:0]}
  function automatic logic [31:0] data_word(input logic valid, input logic [7:0] rx_byte);
    logic [31:0] w;
    w               = '0;
    w[7:0]          = rx_byte;
    w[RX_VALID_BIT] = valid;
    return w;
  endfunction

  // {28'b0, frame_err, overrun, full, !empty}
  function automatic logic [31:0] stat_word(input logic frame_err, input logic overrun,
                                            input logic full, input logic nempty);
    logic [31:0] w;
    w            = '0;
    w[ST_NEMPTY] = nempty;
    w[ST_FULL]   = full;
    w[ST_OVR]    = overrun;
    w[ST_FERR]   = frame_err;
    return w;
  endfunction

endpackage

// File: rtl/uart_rx_mmio_fifo.sv
// rx_fifo
//   Small register-based FIFO holding received bytes. The head entry is
//   visible combinationally so the core gets zero-latency reads.
//   clk, resetn : clock, async active-low reset
//   push, wdata : write one entry (ignored when full unless popping too)
//   pop         : remove the head entry (ignored when empty)
//   head        : current head entry
//   full, empty : occupancy flags
module rx_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] head,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);

  // One extra pointer bit distinguishes full from empty when the
  // index bits are equal.
  logic [AW:0]      wr_ptr_reg;
  logic [AW:0]      rd_ptr_reg;
  logic [WIDTH-1:0] mem_reg [DEPTH];
  logic [DEPTH-1:0] wr_sel;
  logic             push_en;
  logic             pop_en;

  assign empty   = (wr_ptr_reg == rd_ptr_reg);
  assign full    = (wr_ptr_reg[AW] != rd_ptr_reg[AW]) &&
                   (wr_ptr_reg[AW-1:0] == rd_ptr_reg[AW-1:0]);
  assign pop_en  = pop & ~empty;
  // When full, a simultaneous pop frees the slot being written.
  assign push_en = push & (~full | pop_en);
  assign head    = mem_reg[rd_ptr_reg[AW-1:0]];

  for (genvar gi = 0; gi < DEPTH; gi++) begin : g_wr_sel
    assign wr_sel[gi] = push_en && (wr_ptr_reg[AW-1:0] == AW'(gi));
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      for (int i = 0; i < DEPTH; i++) mem_reg[i] <= '0;
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        if (wr_sel[i]) mem_reg[i] <= wdata;
      end
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
    end else begin
      if (push_en) wr_ptr_reg <= wr_ptr_reg + (AW+1)'(1);
      if (pop_en)  rd_ptr_reg <= rd_ptr_reg + (AW+1)'(1);
    end
  end

endmodule

// File: rtl/uart_rx_mmio.sv
// uart_rx_mmio
//   8N1 UART receiver feeding a small FIFO, read by the core through a
//   memory-mapped data register and status register.
//   clk        : system clock
//   resetn     : async active-low reset
//   rxd        : raw UART line (asynchronous, idles high)
//   i_sel_data : data register addressed this cycle
//   i_sel_stat : status register addressed this cycle
//   i_rd       : read strobe, qualifies the selects for side effects
//   o_rdata    : selected register image (0 when nothing selected)
//   o_rx_avail : FIFO holds at least one byte
module uart_rx_mmio
  import uart_pkg::*;
#(
  parameter int CLK_FREQ_HZ = 100_000_000,
  parameter int BAUD_RATE   = 1_000_000,
  parameter int FIFO_DEPTH  = 4
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        rxd,
  input  logic        i_sel_data,
  input  logic        i_sel_stat,
  input  logic        i_rd,
  output logic [31:0] o_rdata,
  output logic        o_rx_avail
);

  localparam int DIV = CLK_FREQ_HZ / BAUD_RATE;
  localparam int CW  = (DIV > 2) ? $clog2(DIV) : 1;
  localparam logic [CW-1:0] HALF_LOAD = CW'(DIV / 2 - 1);
  localparam logic [CW-1:0] FULL_LOAD = CW'(DIV - 1);

  if (DIV < 8) begin : g_div_check
    $error("uart_rx_mmio: clock divider %0d is below 8", DIV);
  end
  if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_depth_check
    $error("uart_rx_mmio: FIFO_DEPTH %0d must be a power of two >= 2", FIFO_DEPTH);
  end

  // Input synchroniser; both flops reset to the idle line level so a
  // reset never looks like a start bit.
  logic rxd_meta_reg;
  logic rxs_reg;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      rxd_meta_reg <= 1'b1;
      rxs_reg      <= 1'b1;
    end else begin
      rxd_meta_reg <= rxd;
      rxs_reg      <= rxd_meta_reg;
    end
  end

  rx_state_t     state_reg, state_next;
  logic [CW-1:0] cnt_reg, cnt_next;
  logic [2:0]    bit_reg, bit_next;
  logic [7:0]    shift_reg, shift_next;
  logic          frame_err_reg, frame_err_next;
  logic          overrun_reg, overrun_next;

  logic          tick;
  logic          fifo_push;
  logic          fifo_pop;
  logic          fifo_full;
  logic          fifo_empty;
  logic [7:0]    fifo_head;
  logic          set_ferr;
  logic          set_ovr;
  logic          rd_data;
  logic          rd_stat;

  assign tick     = (cnt_reg == '0);
  // Data select wins when both are high: pops, and status stays intact.
  assign rd_data  = i_rd & i_sel_data;
  assign rd_stat  = i_rd & i_sel_stat & ~i_sel_data;
  assign fifo_pop = rd_data & ~fifo_empty;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_reg     <= IDLE;
      cnt_reg       <= '0;
      bit_reg       <= '0;
      shift_reg     <= '0;
      frame_err_reg <= 1'b0;
      overrun_reg   <= 1'b0;
    end else begin
      state_reg     <= state_next;
      cnt_reg       <= cnt_next;
      bit_reg       <= bit_next;
      shift_reg     <= shift_next;
      frame_err_reg <= frame_err_next;
      overrun_reg   <= overrun_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    bit_next   = bit_reg;
    shift_next = shift_reg;
    fifo_push  = 1'b0;
    set_ferr   = 1'b0;
    set_ovr    = 1'b0;

    unique case (state_reg)
      IDLE: begin
        // First half-period lands the next tick on the start-bit centre.
        if (!rxs_reg) begin
          cnt_next   = HALF_LOAD;
          state_next = START;
        end
      end
      START: begin
        if (tick) begin
          if (rxs_reg) begin
            state_next = IDLE;
          end else begin
            cnt_next   = FULL_LOAD;
            bit_next   = '0;
            state_next = DATA;
          end
        end else begin
          cnt_next = cnt_reg - CW'(1);
        end
      end
      DATA: begin
        if (tick) begin
          shift_next = {rxs_reg, shift_reg[7:1]};
          cnt_next   = FULL_LOAD;
          bit_next   = bit_reg + 3'd1;
          if (bit_reg == 3'd7) state_next = STOP;
        end else begin
          cnt_next = cnt_reg - CW'(1);
        end
      end
      STOP: begin
        if (tick) begin
          if (rxs_reg) begin
            // A pop in the same cycle makes room even when full.
            if (!fifo_full || fifo_pop) fifo_push = 1'b1;
            else                        set_ovr   = 1'b1;
            state_next = IDLE;
          end else begin
            set_ferr   = 1'b1;
            state_next = BREAK;
          end
        end else begin
          cnt_next = cnt_reg - CW'(1);
        end
      end
      BREAK: begin
        // Held-low line must return high before a new start is accepted.
        if (rxs_reg) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase

    // A set in the same cycle as a status read takes precedence.
    frame_err_next = set_ferr | (frame_err_reg & ~rd_stat);
    overrun_next   = set_ovr  | (overrun_reg   & ~rd_stat);
  end

  rx_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (8)
  ) u_fifo (
    .clk    (clk),
    .resetn (resetn),
    .push   (fifo_push),
    .pop    (fifo_pop),
    .wdata  (shift_reg),
    .head   (fifo_head),
    .full   (fifo_full),
    .empty  (fifo_empty)
  );

  always_comb begin
    o_rdata = '0;
    if (i_sel_data) begin
      o_rdata = data_word(~fifo_empty, fifo_empty ? 8'h00 : fifo_head);
    end else if (i_sel_stat) begin
      o_rdata = stat_word(frame_err_reg, overrun_reg, fifo_full, ~fifo_empty);
    end
  end

  assign o_rx_avail = ~fifo_empty;

endmodule
